mac_pe: RTL and testbench
=========================

# mac_pe

Parametrised systolic processing element, successor to the fixed-width unsigned MAC cell. Each cycle it forwards A east and B south with a valid/last sideband, and accumulates valid products with selectable signed arithmetic and optional saturation. It closes a dot product on a `last` marker and parks the result in a drain register. Drain registers chain through the column so the array controller can shift finished results out while the next dot product is already accumulating.

## Interface
- `DATA_WIDTH`, 8: operand width.
- `ACC_WIDTH`, 32: accumulator and result width; must be ≥ 2*DATA_WIDTH.
- `SIGNED`, 1: 1 = two's-complement operands and accumulator; 0 = unsigned.
- `SATURATE`, 1: 1 = clamp on overflow; 0 = wrap modulo 2^ACC_WIDTH.
- `clk` in 1: clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `a_in` in DATA_WIDTH: A operand from the west.
- `b_in` in DATA_WIDTH: B operand from the north.
- `in_valid` in 1: `a_in`/`b_in` form a valid operand pair.
- `in_last` in 1: qualified by `in_valid`; marks the final pair of a dot product.
- `drain_in` in ACC_WIDTH: result from the upstream PE's drain register.
- `drain_valid_in` in 1: `drain_in` is occupied.
- `drain_en` in 1: shift the drain chain by one position (column-wide).
- `a_out` out DATA_WIDTH: registered `a_in` for the east neighbour.
- `b_out` out DATA_WIDTH: registered `b_in` for the south neighbour.
- `out_valid` out 1: registered `in_valid`.
- `out_last` out 1: registered `in_last & in_valid`.
- `drain_out` out ACC_WIDTH: drain register contents.
- `drain_valid_out` out 1: drain register is occupied.
- `overflow` out 1: sticky; saturation or wrap occurred in the current or last-closed dot product.
- `busy` out 1: high in ACCUM state.

## Operation
- Product: the full 2*DATA_WIDTH product is formed, then sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_WIDTH.
- Sum: `acc + prod` is computed in ACC_WIDTH+1 bits to detect overflow.
  - SATURATE=1, SIGNED=1: clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - SATURATE=1, SIGNED=0: clamp to 2^ACC_WIDTH-1.
  - SATURATE=0: wrap.
  - Detected overflow sets `overflow` in both modes.
- Cycles with `in_valid`=0 leave `acc`, the state and `overflow` unchanged; operands are still forwarded.
- State machine:
  - IDLE: `acc` is treated as 0. A valid pair with `last`=0 loads `acc`=prod, clears `overflow` (then applies this pair's overflow) and goes to ACCUM. A valid pair with `last`=1 captures prod directly and stays in IDLE.
  - ACCUM: a valid pair with `last`=0 updates `acc` to the clamped/wrapped sum. A valid pair with `last`=1 captures that sum, sets `acc`=0 and goes to IDLE.
- Capture: drain register <= final sum and `drain_valid_out` <= 1, regardless of prior occupancy. The overwrite of an unread result is the controller's responsibility.
- Drain: when `drain_en`=1 and no capture occurs that cycle, drain register <= `drain_in` and `drain_valid_out` <= `drain_valid_in`.
- Capture and `drain_en` in the same cycle: capture wins and `drain_in` is discarded.
- `overflow` stays set after capture until the first valid pair of the next dot product.

## Timing
- Forwarding latency is 1 cycle for `a_out`, `b_out`, `out_valid` and `out_last`.
- Capture latency: the result is visible on `drain_out` the cycle after the accepting `last` edge.
- Back-to-back dot products are supported: a new first pair may arrive the cycle after `last`, with no bubble.
- Throughput is one operand pair per cycle.
- Reset values: `a_out`, `b_out`, `out_valid`, `out_last`, `drain_out`, `drain_valid_out`, `overflow`, `busy` all 0; `acc`=0; state IDLE.
- Reset mid-accumulation discards the partial sum and any parked result.
- `reset` has priority over all other inputs.

## Test plan
- Defaults, SIGNED=1: pairs (-3,5), (4,4), (2,-7) with `last` on the third pair → `drain_out`=-13 (0xFFFFFFF3) one cycle later, `drain_valid_out`=1, `busy`=0. `a_out`/`b_out` lag the inputs by 1 cycle.
- SIGNED=0, ACC_WIDTH=16, SATURATE=1: (255,255) repeated twice with `last` on the second pair → 130050 clamps to 0xFFFF and `overflow`=1. Rerun with SATURATE=0 → 0xFC02, `overflow`=1.
- Bubbles and back-to-back: (1,2), idle, (3,4) with `last`, then immediately (5,6) with `last` → captures of 14 then 30 on consecutive result slots; the idle cycle does not change `acc`.
- Drain chain of 3 PEs holding 10, 20, 30 (bottom to top), `drain_en` for 3 cycles → bottom `drain_out` shows 10, 20, 30, then `drain_valid_out`=0.
- Collision: `last` capture of 7 in the same cycle as `drain_en` with `drain_in`=99 → `drain_out`=7.
- Reset mid-operation: `reset` asserted after 2 valid pairs, then pair (2,3) with `last` → result 6; every output was 0 in the cycle after reset.

Source files
------------

// File: rtl/mac_pe.sv
// Systolic MAC processing element: forwards A east / B south, accumulates valid
// products (signed or unsigned, saturating or wrapping) and parks each result in a drain chain.
module mac_pe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter bit          SIGNED     = 1'b1,
    parameter bit          SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [ACC_WIDTH-1:0]  drain_in,
    input  logic                  drain_valid_in,
    input  logic                  drain_en,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [ACC_WIDTH-1:0]  drain_out,
    output logic                  drain_valid_out,
    output logic                  overflow,
    output logic                  busy
);
    localparam int unsigned PW = 2 * DATA_WIDTH;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [PW-1:0]        prod;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH:0]   sum_w;
    logic [ACC_WIDTH-1:0] sum_res;
    logic                 ovf;
    logic                 capture;

    // Operands are widened to the full product width before multiplying.
    always_comb begin
        if (SIGNED)
            prod = PW'($signed(a_in)) * PW'($signed(b_in));
        else
            prod = PW'(a_in) * PW'(b_in);
    end

    generate
        if (ACC_WIDTH > PW) begin : g_ext
            assign prod_ext = {{(ACC_WIDTH - PW){SIGNED & prod[PW-1]}}, prod};
        end else begin : g_noext
            assign prod_ext = prod;
        end
    endgenerate

    // One extra bit on the sum exposes carry-out / signed overflow.
    always_comb begin
        base    = (state == ACCUM) ? acc : '0;
        sum_w   = {SIGNED & base[ACC_WIDTH-1], base}
                + {SIGNED & prod_ext[ACC_WIDTH-1], prod_ext};
        ovf     = SIGNED ? (sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1]) : sum_w[ACC_WIDTH];
        sum_res = sum_w[ACC_WIDTH-1:0];
        if (ovf && SATURATE) begin
            if (SIGNED)
                sum_res = sum_w[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            else
                sum_res = '1;
        end
    end

    assign capture = in_valid & in_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            acc             <= '0;
            a_out           <= '0;
            b_out           <= '0;
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            drain_out       <= '0;
            drain_valid_out <= 1'b0;
            overflow        <= 1'b0;
            busy            <= 1'b0;
        end else begin
            a_out     <= a_in;
            b_out     <= b_in;
            out_valid <= in_valid;
            out_last  <= capture;

            // First pair of a dot product (IDLE) restarts the sticky overflow.
            if (in_valid) begin
                overflow <= ((state == ACCUM) ? overflow : 1'b0) | ovf;
                if (in_last) begin
                    acc   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    acc   <= sum_res;
                    state <= ACCUM;
                    busy  <= 1'b1;
                end
            end

            // Capture beats the chain shift when both land in one cycle.
            if (capture) begin
                drain_out       <= sum_res;
                drain_valid_out <= 1'b1;
            end else if (drain_en) begin
                drain_out       <= drain_in;
                drain_valid_out <= drain_valid_in;
            end
        end
    end
endmodule

// File: tb/tb_mac_pe.sv
// Directed bench for mac_pe: signed default cell, 16-bit unsigned/signed variants
// and a three-deep drain chain, all checked against hand-computed values.
module tb_mac_pe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Main signed 8x8 -> 32 saturating cell
    logic [7:0]  m_a, m_b, m_aout, m_bout;
    logic        m_v, m_l, m_dvin, m_den, m_ov, m_ol, m_dvout, m_ovf, m_busy;
    logic [31:0] m_din, m_dout;

    mac_pe dut (
        .clk(clk), .reset(reset), .a_in(m_a), .b_in(m_b), .in_valid(m_v), .in_last(m_l),
        .drain_in(m_din), .drain_valid_in(m_dvin), .drain_en(m_den),
        .a_out(m_aout), .b_out(m_bout), .out_valid(m_ov), .out_last(m_ol),
        .drain_out(m_dout), .drain_valid_out(m_dvout), .overflow(m_ovf), .busy(m_busy)
    );

    // 16-bit variants sharing one operand stream
    logic [7:0]  u_a, u_b;
    logic        u_v, u_l;
    logic [7:0]  us_ao, us_bo, uw_ao, uw_bo, ss_ao, ss_bo;
    logic        us_ov, us_ol, us_dv, us_ovf, us_busy;
    logic        uw_ov, uw_ol, uw_dv, uw_ovf, uw_busy;
    logic        ss_ov, ss_ol, ss_dv, ss_ovf, ss_busy;
    logic [15:0] us_d, uw_d, ss_d;

    mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b0), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .a_in(u_a), .b_in(u_b), .in_valid(u_v), .in_last(u_l),
        .drain_in(16'h0), .drain_valid_in(1'b0), .drain_en(1'b0),
        .a_out(us_ao), .b_out(us_bo), .out_valid(us_ov), .out_last(us_ol),
        .drain_out(us_d), .drain_valid_out(us_dv), .overflow(us_ovf), .busy(us_busy)
    );
    mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b0), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .a_in(u_a), .b_in(u_b), .in_valid(u_v), .in_last(u_l),
        .drain_in(16'h0), .drain_valid_in(1'b0), .drain_en(1'b0),
        .a_out(uw_ao), .b_out(uw_bo), .out_valid(uw_ov), .out_last(uw_ol),
        .drain_out(uw_d), .drain_valid_out(uw_dv), .overflow(uw_ovf), .busy(uw_busy)
    );
    mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b1)) s_sat (
        .clk(clk), .reset(reset), .a_in(u_a), .b_in(u_b), .in_valid(u_v), .in_last(u_l),
        .drain_in(16'h0), .drain_valid_in(1'b0), .drain_en(1'b0),
        .a_out(ss_ao), .b_out(ss_bo), .out_valid(ss_ov), .out_last(ss_ol),
        .drain_out(ss_d), .drain_valid_out(ss_dv), .overflow(ss_ovf), .busy(ss_busy)
    );

    // Drain chain: index 0 is the bottom PE, index 3 is the empty top feed
    logic [7:0]  c_a [0:2];
    logic [7:0]  c_b [0:2];
    logic [7:0]  c_ao [0:2];
    logic [7:0]  c_bo [0:2];
    logic        c_ov [0:2];
    logic        c_ol [0:2];
    logic        c_ovf [0:2];
    logic        c_busy [0:2];
    logic [31:0] c_d [0:3];
    logic        c_dv [0:3];
    logic        c_v, c_l, c_den;

    assign c_d[3]  = 32'h0;
    assign c_dv[3] = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_chain
        mac_pe pe (
            .clk(clk), .reset(reset), .a_in(c_a[g]), .b_in(c_b[g]), .in_valid(c_v), .in_last(c_l),
            .drain_in(c_d[g+1]), .drain_valid_in(c_dv[g+1]), .drain_en(c_den),
            .a_out(c_ao[g]), .b_out(c_bo[g]), .out_valid(c_ov[g]), .out_last(c_ol[g]),
            .drain_out(c_d[g]), .drain_valid_out(c_dv[g]), .overflow(c_ovf[g]), .busy(c_busy[g])
        );
    end

    task automatic m_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
        m_a = a; m_b = b; m_v = 1'b1; m_l = last;
        step();
        m_v = 1'b0; m_l = 1'b0;
    endtask

    task automatic u_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
        u_a = a; u_b = b; u_v = 1'b1; u_l = last;
        step();
        u_v = 1'b0; u_l = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        m_a = '0; m_b = '0; m_v = 0; m_l = 0; m_din = '0; m_dvin = 0; m_den = 0;
        u_a = '0; u_b = '0; u_v = 0; u_l = 0;
        c_v = 0; c_l = 0; c_den = 0;
        for (int i = 0; i < 3; i++) begin c_a[i] = '0; c_b[i] = '0; end
        step(); step();
        check("rst_dout", m_dout, 32'h0);
        check("rst_dvalid", {31'h0, m_dvout}, 32'h0);
        check("rst_busy", {31'h0, m_busy}, 32'h0);
        reset = 1'b0;

        // (-3*5) + (4*4) + (2*-7) = -13
        m_pair(8'hFD, 8'h05, 1'b0);
        check("fwd_a", {24'h0, m_aout}, 32'hFD);
        check("fwd_b", {24'h0, m_bout}, 32'h05);
        check("busy_accum", {31'h0, m_busy}, 32'h1);
        m_pair(8'h04, 8'h04, 1'b0);
        m_pair(8'h02, 8'hF9, 1'b1);
        check("dot_result", m_dout, 32'hFFFF_FFF3);
        check("dot_dvalid", {31'h0, m_dvout}, 32'h1);
        check("dot_busy", {31'h0, m_busy}, 32'h0);
        check("dot_last", {31'h0, m_ol}, 32'h1);
        check("dot_ovf", {31'h0, m_ovf}, 32'h0);

        // Bubble then back-to-back dot products: 2+12=14, then 30
        m_pair(8'd1, 8'd2, 1'b0);
        step();
        check("bubble_busy", {31'h0, m_busy}, 32'h1);
        check("bubble_hold", m_dout, 32'hFFFF_FFF3);
        m_pair(8'd3, 8'd4, 1'b1);
        check("b2b_first", m_dout, 32'd14);
        m_pair(8'd5, 8'd6, 1'b1);
        check("b2b_second", m_dout, 32'd30);
        check("b2b_busy", {31'h0, m_busy}, 32'h0);

        // Capture and drain shift in the same cycle: capture wins
        m_din = 32'd99; m_dvin = 1'b1; m_den = 1'b1;
        m_pair(8'd7, 8'd1, 1'b1);
        check("collide", m_dout, 32'd7);
        step();
        check("drain_shift", m_dout, 32'd99);
        m_den = 1'b0; m_dvin = 1'b0;

        // Reset mid-accumulation, with a valid last pair held during reset
        m_pair(8'd1, 8'd1, 1'b0);
        m_pair(8'd1, 8'd1, 1'b0);
        m_a = 8'd9; m_b = 8'd9; m_v = 1'b1; m_l = 1'b1; reset = 1'b1;
        step();
        check("mrst_a", {24'h0, m_aout}, 32'h0);
        check("mrst_b", {24'h0, m_bout}, 32'h0);
        check("mrst_ov", {31'h0, m_ov}, 32'h0);
        check("mrst_ol", {31'h0, m_ol}, 32'h0);
        check("mrst_dout", m_dout, 32'h0);
        check("mrst_dv", {31'h0, m_dvout}, 32'h0);
        check("mrst_ovf", {31'h0, m_ovf}, 32'h0);
        check("mrst_busy", {31'h0, m_busy}, 32'h0);
        reset = 1'b0; m_v = 1'b0; m_l = 1'b0;
        m_pair(8'd2, 8'd3, 1'b1);
        check("post_rst", m_dout, 32'd6);
        check("post_rst_dv", {31'h0, m_dvout}, 32'h1);

        // 255*255 twice = 130050: unsigned clamps / wraps; signed view is 1+1
        u_pair(8'hFF, 8'hFF, 1'b0);
        u_pair(8'hFF, 8'hFF, 1'b1);
        check("usat_val", {16'h0, us_d}, 32'hFFFF);
        check("usat_ovf", {31'h0, us_ovf}, 32'h1);
        check("uwrap_val", {16'h0, uw_d}, 32'hFC02);
        check("uwrap_ovf", {31'h0, uw_ovf}, 32'h1);
        check("s16_small", {16'h0, ss_d}, 32'h2);
        check("s16_small_ovf", {31'h0, ss_ovf}, 32'h0);

        // 0x80*0x80 twice: unsigned 32768 fits; signed +32768 clamps high
        u_pair(8'h80, 8'h80, 1'b0);
        check("ovf_cleared", {31'h0, us_ovf}, 32'h0);
        u_pair(8'h80, 8'h80, 1'b1);
        check("usat_fit", {16'h0, us_d}, 32'h8000);
        check("s16_pos_clamp", {16'h0, ss_d}, 32'h7FFF);
        check("s16_pos_ovf", {31'h0, ss_ovf}, 32'h1);

        // -128*127 three times = -48768: signed clamps low; unsigned 48768
        u_pair(8'h80, 8'h7F, 1'b0);
        u_pair(8'h80, 8'h7F, 1'b0);
        u_pair(8'h80, 8'h7F, 1'b1);
        check("s16_neg_clamp", {16'h0, ss_d}, 32'h8000);
        check("s16_neg_ovf", {31'h0, ss_ovf}, 32'h1);
        check("uwrap_fit", {16'h0, uw_d}, 32'hBE80);
        check("uwrap_fit_ovf", {31'h0, uw_ovf}, 32'h0);

        // Chain holds 10, 20, 30 bottom to top, then shifts out
        c_a[0] = 8'd2; c_b[0] = 8'd5;
        c_a[1] = 8'd4; c_b[1] = 8'd5;
        c_a[2] = 8'd5; c_b[2] = 8'd6;
        c_v = 1'b1; c_l = 1'b1;
        step();
        c_v = 1'b0; c_l = 1'b0;
        check("chain_0", c_d[0], 32'd10);
        c_den = 1'b1;
        step();
        check("chain_1", c_d[0], 32'd20);
        step();
        check("chain_2", c_d[0], 32'd30);
        check("chain_2_dv", {31'h0, c_dv[0]}, 32'h1);
        step();
        check("chain_empty", {31'h0, c_dv[0]}, 32'h0);
        c_den = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
